// File: rtl/hue_pkg.sv
// Shared constants for the hue pipeline: function codes, sector offsets, wrap value.
package hue_pkg;

  localparam logic [1:0] FN_RMAX = 2'b00;
  localparam logic [1:0] FN_GMAX = 2'b01;
  localparam logic [1:0] FN_BMAX = 2'b10;
  localparam logic [1:0] FN_GRAY = 2'b11;

  localparam logic [8:0] HUE_OFS_R = 9'd0;
  localparam logic [8:0] HUE_OFS_G = 9'd120;
  localparam logic [8:0] HUE_OFS_B = 9'd240;

  localparam int HUE_WRAP      = 360;
  localparam int FRAC_BITS_DEF = 8;

  function automatic logic [8:0] hue_ofs(input logic [1:0] fn);
    case (fn)
      FN_GMAX: return HUE_OFS_G;
      FN_BMAX: return HUE_OFS_B;
      default: return HUE_OFS_R;
    endcase
  endfunction

endpackage

// File: rtl/hue_stage1.sv
// Hue back-end: clamp/x60, sector offset, round/wrap to 0..359; 3-cycle pipeline.
// Build option HUE_ROUND_EN selects round-half-up instead of floor truncation.
module hue_stage1
  import hue_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int HUE_W     = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic [1:0]               i_function,
  input  logic                     i_valid,
  output logic [HUE_W-1:0]         o_hue,
  output logic                     o_valid,
  output logic                     o_gray,
  output logic                     o_range_err
);

  localparam int STAGES = 3;
  localparam int SUM_W  = DATA_W + 2;
  localparam logic signed [DATA_W-1:0] ONE  = DATA_W'(1 << FRAC_BITS);
  localparam logic signed [SUM_W-1:0]  WRAP = SUM_W'(HUE_WRAP);

  logic [STAGES:1] vld_pipe_d, vld_pipe_q;

  // stage A
  logic signed [DATA_W-1:0] ratio;
  logic signed [DATA_W-1:0] prod_d, prod_q;
  logic [1:0]               fn_a_d, fn_a_q;
  logic                     rerr_a_d, rerr_a_q;

  // stage B
  logic signed [SUM_W-1:0]  ofs_fx;
  logic signed [SUM_W-1:0]  sum_d, sum_q;
  logic                     gray_b_d, gray_b_q;
  logic                     rerr_b_d, rerr_b_q;

  // stage C
  logic signed [SUM_W-1:0]  rnd, int_c, wrapped;
  logic [HUE_W-1:0]         hue_d, hue_q;
  logic                     gray_d, gray_q;
  logic                     rerr_d, rerr_q;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], i_valid};
    if (!i_rstn) vld_pipe_d = '0;
  end

  // Idle cycles push a zero ratio so stale data never raises range_err.
  always_comb begin
    ratio    = '0;
    rerr_a_d = 1'b0;
    if (i_valid) begin
      if (i_data > ONE) begin
        ratio    = ONE;
        rerr_a_d = 1'b1;
      end else if (i_data < -ONE) begin
        ratio    = -ONE;
        rerr_a_d = 1'b1;
      end else begin
        ratio    = i_data;
      end
    end
    prod_d = (ratio <<< 6) - (ratio <<< 2);
    fn_a_d = i_function;
    if (!i_rstn) begin
      prod_d   = '0;
      fn_a_d   = '0;
      rerr_a_d = 1'b0;
    end
  end

  always_comb begin
    ofs_fx   = SUM_W'(hue_ofs(fn_a_q));
    ofs_fx   = ofs_fx << FRAC_BITS;
    sum_d    = SUM_W'(prod_q) + ofs_fx;
    gray_b_d = vld_pipe_q[1] && (fn_a_q == FN_GRAY);
    rerr_b_d = vld_pipe_q[1] && rerr_a_q;
    if (fn_a_q == FN_GRAY) sum_d = '0;
    if (!i_rstn) begin
      sum_d    = '0;
      gray_b_d = 1'b0;
      rerr_b_d = 1'b0;
    end
  end

`ifdef HUE_ROUND_EN
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC_BITS - 1);
  assign rnd = sum_q + HALF;
`else
  assign rnd = sum_q;
`endif

  // Clamped inputs keep the integer part within one wrap period of 0..359.
  always_comb begin
    int_c   = rnd >>> FRAC_BITS;
    wrapped = int_c;
    if (int_c < 0)          wrapped = int_c + WRAP;
    else if (int_c >= WRAP) wrapped = int_c - WRAP;
    hue_d  = HUE_W'(wrapped);
    gray_d = vld_pipe_q[2] && gray_b_q;
    rerr_d = vld_pipe_q[2] && rerr_b_q;
    if (!i_rstn) begin
      hue_d  = '0;
      gray_d = 1'b0;
      rerr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    vld_pipe_q <= vld_pipe_d;
    prod_q     <= prod_d;
    fn_a_q     <= fn_a_d;
    rerr_a_q   <= rerr_a_d;
    sum_q      <= sum_d;
    gray_b_q   <= gray_b_d;
    rerr_b_q   <= rerr_b_d;
    hue_q      <= hue_d;
    gray_q     <= gray_d;
    rerr_q     <= rerr_d;
  end

  assign o_hue       = hue_q;
  assign o_valid     = vld_pipe_q[STAGES];
  assign o_gray      = gray_q;
  assign o_range_err = rerr_q;

endmodule

// File: tb/tb_hue_stage1.sv
// Self-checking bench for hue_stage1: directed corner samples plus random streams
// against a real-arithmetic hue model; honours HUE_ROUND_EN like the design.
module tb_hue_stage1;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [15:0] i_data;
  logic [1:0]  i_function;
  logic        i_valid;
  logic [8:0]  o_hue;
  logic        o_valid;
  logic        o_gray;
  logic        o_range_err;

  int n_assert = 0;
  int n_fail   = 0;

  // expected samples in flight; index 2 is what the outputs must show now
  logic mv[3];
  int   mh[3];
  logic mg[3];
  logic me[3];

  hue_stage1 dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_data      (i_data),
    .i_function  (i_function),
    .i_valid     (i_valid),
    .o_hue       (o_hue),
    .o_valid     (o_valid),
    .o_gray      (o_gray),
    .o_range_err (o_range_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic int ref_hue(input logic [1:0] fn, input logic [15:0] d);
    real r, h;
    int  fl;
    if (fn == 2'b11) return 0;
    r = $signed(d) / 256.0;
    if (r > 1.0)  r = 1.0;
    if (r < -1.0) r = -1.0;
    h = 60.0 * r + ((fn == 2'b00) ? 0.0 : (fn == 2'b01) ? 120.0 : 240.0);
`ifdef HUE_ROUND_EN
    h = h + 0.5;
`endif
    fl = int'($floor(h));
    fl = fl % 360;
    if (fl < 0) fl = fl + 360;
    return fl;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic rst_n, input logic v, input logic [1:0] fn, input logic [15:0] d);
    int sd;
    @(negedge i_clk);
    i_rstn = rst_n; i_valid = v; i_function = fn; i_data = d;
    @(posedge i_clk);
    #1;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mv[k] = 1'b0; mh[k] = 0; mg[k] = 1'b0; me[k] = 1'b0;
      end
    end else begin
      for (int k = 2; k > 0; k--) begin
        mv[k] = mv[k-1]; mh[k] = mh[k-1]; mg[k] = mg[k-1]; me[k] = me[k-1];
      end
      sd    = $signed(d);
      mv[0] = v;
      mh[0] = ref_hue(fn, d);
      mg[0] = v && (fn == 2'b11);
      me[0] = v && (sd > 256 || sd < -256);
    end
    chk("valid", 32'(o_valid), 32'(mv[2]));
    chk("gray", 32'(o_gray), 32'(mg[2]));
    chk("range_err", 32'(o_range_err), 32'(me[2]));
    if (mv[2] || !rst_n) chk("hue", 32'(o_hue), 32'(mh[2]));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 2'b00, 16'h0000);
  endtask

  initial begin
    logic [15:0] rd;
    logic [1:0]  rf;
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; mh[k] = 0; mg[k] = 1'b0; me[k] = 1'b0;
    end
    i_rstn = 1'b0; i_valid = 1'b0; i_function = 2'b00; i_data = 16'h0000;

    // reset state
    cyc(1'b0, 1'b0, 2'b00, 16'h0000);
    cyc(1'b0, 1'b1, 2'b11, 16'h0300);
    idle(2);

    // directed corner samples, isolated pulses
    cyc(1'b1, 1'b1, 2'b00, 16'h0080); idle(3);   // 30
    cyc(1'b1, 1'b1, 2'b00, 16'hFF80); idle(3);   // 330
    cyc(1'b1, 1'b1, 2'b01, 16'h0100); idle(3);   // 180
    cyc(1'b1, 1'b1, 2'b10, 16'h0000); idle(3);   // 240
    cyc(1'b1, 1'b1, 2'b11, 16'h0040); idle(3);   // gray
    cyc(1'b1, 1'b1, 2'b00, 16'h0300); idle(3);   // clamp +
    cyc(1'b1, 1'b1, 2'b00, 16'hFD00); idle(3);   // clamp -
    cyc(1'b1, 1'b1, 2'b00, 16'hFFFF); idle(3);   // 359 or 0
    cyc(1'b1, 1'b1, 2'b00, 16'h0003); idle(3);   // 0 or 1
    cyc(1'b1, 1'b1, 2'b10, 16'h0100); idle(3);   // 300
    cyc(1'b1, 1'b1, 2'b00, 16'hFF00); idle(3);   // 300
    cyc(1'b1, 1'b1, 2'b01, 16'h8000); idle(3);   // most negative input

    // 8 back-to-back, then a 1-cycle gap
    for (int k = 0; k < 8; k++) begin
      rd = 16'($urandom_range(0, 1023)) - 16'd512;
      rf = 2'($urandom_range(0, 3));
      cyc(1'b1, 1'b1, rf, rd);
    end
    cyc(1'b1, 1'b0, 2'b01, 16'h0055);
    cyc(1'b1, 1'b1, 2'b10, 16'hFFC0);
    cyc(1'b1, 1'b1, 2'b01, 16'h00C0);
    idle(4);

    // random stream with random valid and occasional full-range data
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) rd = 16'($urandom);
      else                           rd = 16'($urandom_range(0, 1023)) - 16'd512;
      rf = 2'($urandom_range(0, 3));
      cyc(1'b1, 1'($urandom_range(0, 4) != 0), rf, rd);
    end

    // reset mid-stream, then idle, then a lone sample
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 2'b01, 16'h0020);
    cyc(1'b0, 1'b1, 2'b01, 16'h0020);
    idle(4);
    cyc(1'b1, 1'b1, 2'b10, 16'hFFE0);
    idle(4);

    // reset mid-stream with valids resuming immediately after release
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 2'b00, 16'h0200);
    cyc(1'b0, 1'b1, 2'b00, 16'h0200);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 2'b01, 16'($urandom_range(0, 255)));
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
